// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared cache-line types and arbiter state encoding
package rv32i_types;

  localparam int LINE_BITS      = 256;
  localparam int BEAT_BITS      = 64;
  localparam int BEATS_PER_LINE = LINE_BITS / BEAT_BITS;

  typedef logic [LINE_BITS-1:0] cacheline_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_BURST,
    RESP
  } arb_state_t;

endpackage

// File: rtl/cacheline_arbiter_line_serdes.sv
// rtl/cacheline_arbiter_line_serdes.sv - line buffer, beat counter, beat gather/select
module line_serdes #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int BEATS  = LINE_W / BEAT_W,
  parameter int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              gather,
  input  logic [BEAT_W-1:0] beat_in,
  input  logic              advance,
  output logic [LINE_W-1:0] line,
  output logic [BEAT_W-1:0] beat_out,
  output logic              last_beat
);

  logic [CNT_W-1:0] cnt;

  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign beat_out  = line[int'(cnt)*BEAT_W +: BEAT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
      cnt  <= '0;
    end else begin
      if (load) begin
        line <= load_line;
      end else if (gather) begin
        line[int'(cnt)*BEAT_W +: BEAT_W] <= beat_in;
      end
      // Counter returns to zero after the final beat so the next burst starts at beat 0.
      if (gather || advance) begin
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// rtl/cacheline_arbiter.sv - round-robin icache/dcache arbiter onto one burst memory port
module cacheline_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = LINE_BITS,
  parameter int BEAT_W = BEAT_BITS,
  parameter int BEATS  = LINE_W / BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic              bmem_rvalid,
  input  logic [BEAT_W-1:0] bmem_rdata
);

  localparam int OFF_W = $clog2(LINE_W / 8);

  arb_state_t        state, state_next;
  logic              gnt_d;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic              i_pend, d_pend, pick_d, grant;
  logic [ADDR_W-1:0] sel_addr;
  logic              gather, advance, last_beat;
  logic [LINE_W-1:0] line;
  logic [BEAT_W-1:0] beat;

  assign i_pend   = i_read;
  assign d_pend   = d_read | d_write;
  // gnt_d remembers the last grantee; on contention the other side wins.
  assign pick_d   = d_pend && (!i_pend || !gnt_d);
  assign grant    = (state == IDLE) && (i_pend || d_pend);
  assign sel_addr = pick_d ? d_addr : i_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_d  <= 1'b0;
      op_wr  <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        gnt_d  <= pick_d;
        op_wr  <= pick_d && d_write;
        addr_q <= {sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      end
    end
  end

  always_comb begin
    state_next = state;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    gather     = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (grant) state_next = (pick_d && d_write) ? WR_BURST : RD_ISSUE;
      end
      RD_ISSUE: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
        if (bmem_ready) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (bmem_rvalid) begin
          gather = 1'b1;
          if (last_beat) state_next = RESP;
        end
      end
      WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = beat;
        if (bmem_ready) begin
          advance = 1'b1;
          if (last_beat) state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
        if (gnt_d) begin
          d_resp = 1'b1;
          if (!op_wr) d_rdata = line;
        end else begin
          i_resp  = 1'b1;
          i_rdata = line;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  line_serdes #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS)
  ) u_serdes (
    .clk       (clk),
    .rst       (rst),
    .load      (grant && pick_d && d_write),
    .load_line (d_wdata),
    .gather    (gather),
    .beat_in   (bmem_rdata),
    .advance   (advance),
    .line      (line),
    .beat_out  (beat),
    .last_beat (last_beat)
  );

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb/tb_cacheline_arbiter.sv - directed and randomized checks of cacheline_arbiter
module tb_cacheline_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int NB     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_addr, d_addr, bmem_addr;
  logic              i_read, i_resp, d_read, d_write, d_resp;
  logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata;
  logic              bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [BEAT_W-1:0] bmem_wdata, bmem_rdata;

  always #5 clk = ~clk;

  cacheline_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .BEATS(NB)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rvalid(bmem_rvalid),
    .bmem_rdata(bmem_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_val(input int c);
    logic [3:0] n;
    n = 4'(c - 1);
    return {16{n}};
  endfunction

  // Transaction-level reference: who owns the port, how far the burst has got, and the line.
  logic              m_valid = 1'b0;
  logic              m_active, m_resp, m_last_d, m_who_d, m_wr, m_cmd_done;
  int                m_nbeats;
  logic [ADDR_W-1:0] m_addr;
  logic [63:0]       m_rline [NB];
  logic [63:0]       m_wline [NB];

  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_resp   = 1'b0;
      m_last_d = 1'b0;
      m_nbeats = 0;
    end else if (m_valid) begin
      if (m_resp) begin
        m_resp   = 1'b0;
        m_active = 1'b0;
      end else if (!m_active) begin
        if (i_read || d_read || d_write) begin
          m_who_d    = (d_read || d_write) && !(i_read && m_last_d);
          m_last_d   = m_who_d;
          m_wr       = m_who_d && d_write;
          m_addr     = (m_who_d ? d_addr : i_addr) & ~32'h1f;
          for (int b = 0; b < NB; b++) m_wline[b] = d_wdata[64*b +: 64];
          m_cmd_done = m_wr;
          m_nbeats   = 0;
          m_active   = 1'b1;
        end
      end else if (!m_cmd_done) begin
        if (bmem_ready) m_cmd_done = 1'b1;
      end else if (m_wr) begin
        if (bmem_ready) begin
          m_nbeats++;
          if (m_nbeats == NB) m_resp = 1'b1;
        end
      end else if (bmem_rvalid) begin
        m_rline[m_nbeats] = bmem_rdata;
        m_nbeats++;
        if (m_nbeats == NB) m_resp = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic e_read, e_write;
      logic [LINE_W-1:0] e_line;
      e_read  = m_active && !m_resp && !m_cmd_done;
      e_write = m_active && !m_resp && m_wr;
      e_line  = {m_rline[3], m_rline[2], m_rline[1], m_rline[0]};
      check("bmem_read", bmem_read, e_read);
      check("bmem_write", bmem_write, e_write);
      if (e_read || e_write) check("bmem_addr", bmem_addr, m_addr);
      if (e_write && m_nbeats < NB) check("bmem_wdata", bmem_wdata, m_wline[m_nbeats]);
      check("i_resp", i_resp, m_resp && !m_who_d);
      check("d_resp", d_resp, m_resp && m_who_d);
      check("i_rdata", i_rdata, (m_resp && !m_who_d) ? e_line : '0);
      check("d_rdata", d_rdata, (m_resp && m_who_d && !m_wr) ? e_line : '0);
    end
  end

  // Directed window driver: cycle c runs between edge N+c-1 and edge N+c.
  logic [63:0]       wd_log [32];
  logic [ADDR_W-1:0] ad_log [32];
  logic              rd_log [32];
  logic              wr_log [32];
  int                i_cyc [4];
  int                d_cyc [4];
  int                i_cnt, d_cnt;
  logic [LINE_W-1:0] i_cap, d_cap;

  task automatic run_win(input int ncyc, input logic [31:0] rdy, input logic [31:0] rv,
                         input int i_need, input int d_need, input int i_drop_c, input int d_raise_c);
    i_cnt = 0;
    d_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      i_cyc[k] = 0;
      d_cyc[k] = 0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      bmem_ready  = rdy[c-1];
      bmem_rvalid = rv[c-1];
      bmem_rdata  = beat_val(c);
      if (i_cnt >= i_need) i_read = 1'b0;
      if (d_cnt >= d_need) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
      if (c == i_drop_c) i_read = 1'b0;
      if (c == d_raise_c) d_read = 1'b1;
      @(negedge clk);
      rd_log[c] = bmem_read;
      wr_log[c] = bmem_write;
      wd_log[c] = bmem_wdata;
      ad_log[c] = bmem_addr;
      if (i_resp) begin
        if (i_cnt < 4) i_cyc[i_cnt] = c;
        i_cnt++;
        i_cap = i_rdata;
      end
      if (d_resp) begin
        if (d_cnt < 4) d_cyc[d_cnt] = c;
        d_cnt++;
        d_cap = d_rdata;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bmem_read, bmem_write, bmem_addr, bmem_wdata, i_resp, d_resp}, '0);
    check({name, "_rdata"}, i_rdata | d_rdata, '0);
  endtask

  logic i_got, d_got;
  int   i_done, d_done;

  initial begin
    rst = 1'b1;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_outputs");

    // Icache read, back-to-back beats.
    i_addr = 32'h6000_0024;
    i_read = 1'b1;
    run_win(8, 32'hFFFF_FFFF, 32'h0000_001E, 1, 0, 0, 0);
    check("t1_cmd_cycle", rd_log[1], 1'b1);
    check("t1_cmd_single", rd_log[2], 1'b0);
    check("t1_addr", ad_log[1], 32'h6000_0020);
    check("t1_resp_cycle", i_cyc[0], 6);
    check("t1_resp_count", i_cnt, 1);
    check("t1_no_d_resp", d_cnt, 0);
    check("t1_line", i_cap, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Dcache writeback with stalls; rvalid noise throughout.
    d_addr  = 32'h1234_5678;
    d_wdata = {64'hD3D3_D3D3_D3D3_D3D3, 64'hC2C2_C2C2_C2C2_C2C2,
               64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};
    d_write = 1'b1;
    run_win(9, 32'hFFFF_FFED, 32'hFFFF_FFFF, 0, 1, 0, 0);
    check("t2_beat1", wd_log[1], 64'hA0A0_A0A0_A0A0_A0A0);
    check("t2_beat2", wd_log[2], 64'hB1B1_B1B1_B1B1_B1B1);
    check("t2_beat3", wd_log[3], 64'hB1B1_B1B1_B1B1_B1B1);
    check("t2_beat4", wd_log[4], 64'hC2C2_C2C2_C2C2_C2C2);
    check("t2_beat5", wd_log[5], 64'hD3D3_D3D3_D3D3_D3D3);
    check("t2_beat6", wd_log[6], 64'hD3D3_D3D3_D3D3_D3D3);
    check("t2_addr_held", {ad_log[1], ad_log[6]}, {32'h1234_5660, 32'h1234_5660});
    check("t2_burst_over", wr_log[7], 1'b0);
    check("t2_resp_cycle", d_cyc[0], 7);
    check("t2_counts", {i_cnt, d_cnt}, {32'd0, 32'd1});

    // rvalid during idle and during the command phase must not land in the line.
    bmem_rvalid = 1'b1;
    bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) @(negedge clk);
    i_addr = 32'h0000_0040;
    i_read = 1'b1;
    run_win(11, 32'hFFFF_FFFE, 32'h0000_00B7, 1, 0, 0, 0);
    check("t4_resp_cycle", i_cyc[0], 9);
    check("t4_line", i_cap, {64'h7777_7777_7777_7777, 64'h5555_5555_5555_5555,
                             64'h4444_4444_4444_4444, 64'h2222_2222_2222_2222});

    // Simultaneous requests: dcache first after reset, then alternation.
    i_addr = 32'h0000_0100;
    d_addr = 32'h0000_0200;
    i_read = 1'b1;
    d_read = 1'b1;
    run_win(22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 2, 0, 0);
    check("t3_d_first", d_cyc[0], 6);
    check("t3_i_second", i_cyc[0], 13);
    check("t3_d_third", d_cyc[1], 20);
    check("t3_counts", {i_cnt, d_cnt}, {32'd1, 32'd2});

    // Reset in the middle of a read after two beats.
    i_addr = 32'h0000_1000;
    i_read = 1'b1;
    run_win(3, 32'hFFFF_FFFF, 32'h0000_0006, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_read = 1'b0;
    bmem_rvalid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("t5_after_reset");
    repeat (2) @(negedge clk);
    i_addr = 32'h0000_2000;
    i_read = 1'b1;
    run_win(10, 32'hFFFF_FFFF, 32'h0000_003C, 1, 0, 0, 0);
    check("t5_resp_cycle", i_cyc[0], 7);
    check("t5_fresh_line", i_cap, {64'h5555_5555_5555_5555, 64'h4444_4444_4444_4444,
                                   64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222});

    // Icache drops its request mid-transfer while a dcache read waits.
    i_addr = 32'h0000_3000;
    d_addr = 32'h4000_0008;
    i_read = 1'b1;
    run_win(15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 3, 2);
    check("t6_i_resp_cycle", i_cyc[0], 6);
    check("t6_d_resp_cycle", d_cyc[0], 13);
    check("t6_counts", {i_cnt, d_cnt}, {32'd1, 32'd1});
    check("t6_d_line", d_cap, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA,
                               64'h9999_9999_9999_9999, 64'h8888_8888_8888_8888});

    // Randomized traffic with stalls, rvalid noise, illegal read+write and occasional reset.
    i_got = 1'b0; d_got = 1'b0; i_done = 0; d_done = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_got = 1'b0; d_got = 1'b0;
      end
      if (!rst) begin
        if (i_got) begin
          i_got  = 1'b0;
          i_read = 1'b0;
        end
        if (!i_read && $urandom_range(0, 2) == 0) begin
          i_read = 1'b1;
          i_addr = $urandom;
        end
        if (d_got) begin
          d_got   = 1'b0;
          d_read  = 1'b0;
          d_write = 1'b0;
        end
        if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
          int r;
          r       = $urandom_range(0, 9);
          d_read  = (r < 4) || (r == 9);
          d_write = (r >= 4);
          d_addr  = $urandom;
          for (int w = 0; w < 8; w++) d_wdata[32*w +: 32] = $urandom;
        end
      end
      bmem_ready  = ($urandom_range(0, 3) != 0);
      bmem_rvalid = $urandom_range(0, 1);
      bmem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      if (i_resp) begin i_got = 1'b1; i_done++; end
      if (d_resp) begin d_got = 1'b1; d_done++; end
    end
    check("random_i_progress", i_done > 10, 1'b1);
    check("random_d_progress", d_done > 10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
